// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scan-code definitions.
//   - PS2_EXT / PS2_BRK : extended and break prefix bytes
//   - PS2_D_*           : bytes that carry no key information and are discarded
//   - ps2_state_e       : prefix-tracking state of the key decoder
//   - key_event_t       : one decoded key event (also consumed by the password FSM)
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;

  localparam logic [7:0] PS2_D_NULL = 8'h00;  // key detection error / overrun
  localparam logic [7:0] PS2_D_BAT  = 8'hAA;  // self-test passed
  localparam logic [7:0] PS2_D_E1   = 8'hE1;  // Pause-key prefix, not decoded
  localparam logic [7:0] PS2_D_ACK  = 8'hFA;  // command acknowledge
  localparam logic [7:0] PS2_D_RSND = 8'hFE;  // resend request
  localparam logic [7:0] PS2_D_ERR  = 8'hFF;  // key detection error / overrun

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_D_NULL) || (b == PS2_D_BAT)  || (b == PS2_D_E1) ||
           (b == PS2_D_ACK)  || (b == PS2_D_RSND) || (b == PS2_D_ERR);
  endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: folds E0/F0 prefixed PS/2 scan-code sequences into single
// key events, filters typematic repeats and tracks the currently held key.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : scan-code byte stream from the receiver
//   in_ready            : byte accepted on in_valid && in_ready
//   key_code/key_ext/key_break/key_valid : single-entry event output
//   key_ready           : consumer takes the event on key_valid && key_ready
//   held_code/held_ext/held_valid        : last pressed key still down
//   err_timeout         : one-cycle pulse when a prefix sequence stalls
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter bit          FILTER_REPEAT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic       held_valid,
  output logic       err_timeout
);

  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    r_state;
  ps2_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  key_event_t    r_evt;
  logic          r_key_valid;
  logic [7:0]    r_held_code;
  logic          r_held_ext;
  logic          r_held_valid;
  logic          r_err;

  logic          w_accept;
  logic          w_is_ext;
  logic          w_is_brk;
  logic          w_complete;
  logic          w_held_match;
  logic          w_emit;
  logic          w_timeout;
  key_event_t    w_evt;

  assign in_ready = !r_key_valid || key_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_is_ext     = (in_data == PS2_EXT);
    w_is_brk     = (in_data == PS2_BRK);
    w_complete   = w_accept && !w_is_ext && !w_is_brk && !is_discard(in_data);
    w_evt.code   = in_data;
    w_evt.ext    = (r_state == EXT) || (r_state == EXT_BRK);
    w_evt.brk    = (r_state == BRK) || (r_state == EXT_BRK);
    w_held_match = r_held_valid && (r_held_code == in_data) && (r_held_ext == w_evt.ext);
    // A make of the key already down is a typematic repeat.
    w_emit       = w_complete && (w_evt.brk || !(FILTER_REPEAT && w_held_match));
    // An accepted byte always beats an expiring timeout.
    w_timeout    = (r_state != IDLE) && !w_accept && (r_cnt == CNT_LAST);

    w_state_nxt = r_state;
    if (w_accept) begin
      if (w_is_ext) begin
        case (r_state)
          IDLE:    w_state_nxt = EXT;
          BRK:     w_state_nxt = EXT_BRK;
          default: w_state_nxt = r_state;
        endcase
      end else if (w_is_brk) begin
        case (r_state)
          IDLE:    w_state_nxt = BRK;
          EXT:     w_state_nxt = EXT_BRK;
          default: w_state_nxt = r_state;
        endcase
      end else begin
        w_state_nxt = IDLE;
      end
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept || w_timeout || (r_state == IDLE)) r_cnt <= '0;
    else                                                   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt        <= '0;
      r_key_valid  <= 1'b0;
      r_held_code  <= '0;
      r_held_ext   <= 1'b0;
      r_held_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_timeout;

      if (w_emit) begin
        r_evt       <= w_evt;
        r_key_valid <= 1'b1;
      end else if (key_ready) begin
        r_key_valid <= 1'b0;
      end

      if (w_emit && !w_evt.brk) begin
        r_held_code  <= in_data;
        r_held_ext   <= w_evt.ext;
        r_held_valid <= 1'b1;
      end else if (w_emit && w_held_match) begin
        r_held_valid <= 1'b0;
      end
    end
  end

  assign key_code    = r_evt.code;
  assign key_ext     = r_evt.ext;
  assign key_break   = r_evt.brk;
  assign key_valid   = r_key_valid;
  assign held_code   = r_held_code;
  assign held_ext    = r_held_ext;
  assign held_valid  = r_held_valid;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       key_ready = 1'b1;

  logic       in_ready, key_ext, key_break, key_valid, held_ext, held_valid, err_timeout;
  logic [7:0] key_code, held_code;
  logic       in_ready2, key_ext2, key_break2, key_valid2, held_ext2, held_valid2, err_timeout2;
  logic [7:0] key_code2, held_code2;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T), .FILTER_REPEAT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break), .key_valid(key_valid),
    .key_ready(key_ready), .held_code(held_code), .held_ext(held_ext),
    .held_valid(held_valid), .err_timeout(err_timeout));

  ps2_key_decoder #(.TIMEOUT_CYCLES(T), .FILTER_REPEAT(1'b0)) dut_nofilt (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .key_code(key_code2), .key_ext(key_ext2), .key_break(key_break2), .key_valid(key_valid2),
    .key_ready(key_ready), .held_code(held_code2), .held_ext(held_ext2),
    .held_valid(held_valid2), .err_timeout(err_timeout2));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: prefix flags, idle-wait count, held key, one-entry output.
  typedef struct {
    logic [7:0] code;
    bit         ext;
    bit         brk;
  } ev_t;

  bit         m_pend, m_ext, m_brk;
  int         m_wait;
  bit         m_kv, m_kext, m_kbrk;
  logic [7:0] m_code;
  bit         m_hv, m_hext;
  logic [7:0] m_hcode;
  bit         m_err;
  int         m_acc_cnt = 0;
  int         err_pulses = 0;
  ev_t        log_q[$];
  bit         acc, consumed, emit, same;
  logic [22:0] got_v, exp_v;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_ext = 0; m_brk = 0; m_wait = 0;
      m_kv = 0; m_code = '0; m_kext = 0; m_kbrk = 0;
      m_hv = 0; m_hcode = '0; m_hext = 0; m_err = 0;
    end else begin
      acc      = in_valid && (!m_kv || key_ready);
      consumed = m_kv && key_ready;
      emit     = 0;
      m_err    = 0;
      if (consumed) log_q.push_back('{m_code, m_kext, m_kbrk});
      if (acc) begin
        m_acc_cnt++;
        m_wait = 0;
        if (in_data == 8'hE0) begin
          m_pend = 1; m_ext = 1;
        end else if (in_data == 8'hF0) begin
          m_pend = 1; m_brk = 1;
        end else begin
          if (!(in_data inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF})) begin
            same = m_hv && (m_hcode == in_data) && (m_hext == m_ext);
            if (m_brk) begin
              emit = 1;
              if (same) m_hv = 0;
            end else if (!same) begin
              emit = 1;
              m_hv = 1; m_hcode = in_data; m_hext = m_ext;
            end
            if (emit) begin
              m_code = in_data; m_kext = m_ext; m_kbrk = m_brk;
            end
          end
          m_pend = 0; m_ext = 0; m_brk = 0;
        end
      end else if (m_pend) begin
        m_wait++;
        if (m_wait == T) begin
          m_pend = 0; m_ext = 0; m_brk = 0; m_wait = 0; m_err = 1;
        end
      end
      if (emit) m_kv = 1;
      else if (consumed) m_kv = 0;
    end
    #1;
    got_v = {key_valid, key_code, key_ext, key_break, held_valid, held_code, held_ext,
             err_timeout, in_ready};
    exp_v = {m_kv, m_code, m_kext, m_kbrk, m_hv, m_hcode, m_hext, m_err, (!m_kv || key_ready)};
    chk("cycle_outputs", 32'(got_v), 32'(exp_v));
    if (err_timeout) err_pulses++;
  end

  int n2_make = 0;
  always @(posedge clk)
    if (!rst && key_valid2 && key_ready && !key_break2) n2_make++;

  task automatic send(input logic [7:0] b);
    int c0;
    int n;
    c0 = m_acc_cnt;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (m_acc_cnt == c0 && n < 200);
    if (m_acc_cnt == c0) chk("send_accept_timeout", 32'(n), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic chk_ev(input string name, input int idx, input logic [7:0] code,
                        input bit ext, input bit brk);
    if (idx >= log_q.size()) chk(name, 32'hDEAD, {22'd0, code, ext, brk});
    else chk(name, {22'd0, log_q[idx].code, log_q[idx].ext, log_q[idx].brk},
             {22'd0, code, ext, brk});
  endtask

  int b0, d0, ep;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // typematic repeat filter (and unfiltered instance counting makes)
    b0 = log_q.size(); d0 = n2_make;
    send(8'h35);
    chk("held_after_make", 32'(held_valid), 32'd1);
    send(8'h35); send(8'h35); send(8'hF0); send(8'h35);
    chk("held_after_break", 32'(held_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("repeat_event_count", 32'(log_q.size() - b0), 32'd2);
    chk_ev("repeat_make", b0, 8'h35, 0, 0);
    chk_ev("repeat_break", b0 + 1, 8'h35, 0, 1);
    chk("nofilter_makes", 32'(n2_make - d0), 32'd3);

    // simple make, one-cycle latency
    send(8'h2C);
    chk("make_valid", 32'(key_valid), 32'd1);
    chk("make_code", 32'(key_code), 32'h2C);
    chk("make_ext_brk", {30'd0, key_ext, key_break}, 32'd0);
    chk("make_held", {23'd0, held_valid, held_code}, {23'd1, 8'h2C});
    @(negedge clk);
    chk("make_valid_drop", 32'(key_valid), 32'd0);

    // extended break
    b0 = log_q.size();
    send(8'hE0); send(8'hF0); send(8'h75);
    repeat (2) @(negedge clk);
    chk("ext_brk_count", 32'(log_q.size() - b0), 32'd1);
    chk_ev("ext_brk_event", b0, 8'h75, 1, 1);

    // back-pressure
    key_ready = 1'b0;
    b0 = log_q.size();
    send(8'h3A);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    fork
      send(8'h4B);
      begin
        repeat (4) @(negedge clk);
        key_ready = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    chk("stall_count", 32'(log_q.size() - b0), 32'd2);
    chk_ev("stall_first", b0, 8'h3A, 0, 0);
    chk_ev("stall_second", b0 + 1, 8'h4B, 0, 0);
    chk("stall_held", 32'(held_code), 32'h4B);

    // prefix timeout
    b0 = log_q.size(); ep = err_pulses;
    send(8'hE0);
    repeat (T + 4) @(negedge clk);
    chk("timeout_pulses", 32'(err_pulses - ep), 32'd1);
    send(8'h6B);
    repeat (2) @(negedge clk);
    chk("after_timeout_count", 32'(log_q.size() - b0), 32'd1);
    chk_ev("after_timeout_event", b0, 8'h6B, 0, 0);

    // reset mid-sequence, then discard bytes
    send(8'hF0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    b0 = log_q.size();
    send(8'h2C);
    repeat (2) @(negedge clk);
    chk("post_rst_count", 32'(log_q.size() - b0), 32'd1);
    chk_ev("post_rst_event", b0, 8'h2C, 0, 0);
    chk("post_rst_held", 32'(held_valid), 32'd1);
    b0 = log_q.size();
    send(8'hAA); send(8'hFA);
    repeat (2) @(negedge clk);
    chk("discard_no_event", 32'(log_q.size() - b0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
